// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode, ALU control and controller state encodings
// Contents: opcode constants, ALUOP_* and ALUSRCB_* encodings, state_t enum.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [2:0] ALUSRCB_RT      = 3'b000;
  localparam logic [2:0] ALUSRCB_FOUR    = 3'b001;
  localparam logic [2:0] ALUSRCB_SIMM    = 3'b010;
  localparam logic [2:0] ALUSRCB_SIMM_SH = 3'b011;
  localparam logic [2:0] ALUSRCB_ZIMM    = 3'b100;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_RTYPEEX = 4'd6,
    ST_RTYPEWB = 4'd7,
    ST_BEQEX   = 4'd8,
    ST_BNEEX   = 4'd9,
    ST_ADDIEX  = 4'd10,
    ST_ORIEX   = 4'd11,
    ST_IMMWB   = 4'd12,
    ST_JEX     = 4'd13,
    ST_ILLEGAL = 4'd14
  } state_t;

endpackage

// File: rtl/wait_ctr.sv
// rtl/wait_ctr.sv - memory wait-state dwell counter
// Ports: clk, reset (sync, active-high), clear (restart at 0), en (count),
//        done (count has reached MEM_LAT; final cycle of the dwell).
module wait_ctr #(
  parameter int MEM_LAT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam int W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

  logic [W-1:0] wcnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wcnt <= '0;
    end else if (en) begin
      wcnt <= wcnt + W'(1);
    end
  end

  assign done = (wcnt == W'(MEM_LAT));

endmodule

// File: rtl/mc_maindec.sv
// rtl/mc_maindec.sv - multicycle MIPS main controller (Moore FSM)
// Ports: clk, reset (sync, active-high), op (opcode, used in DECODE);
//        strobes pcwrite/irwrite/memwrite/regwrite, branch/branchNot/illegal,
//        selects iord, alusrca, alusrcb, aluop, regdst, memtoreg, pcsrc.
module mc_maindec
  import mips_pkg::*;
#(
  parameter int MEM_LAT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [2:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] pcsrc,
  output logic       branch,
  output logic       branchNot,
  output logic       illegal
);

  state_t     state;
  state_t     next_state;
  logic [5:0] op_q;
  logic       wait_st;
  logic       done;

  // Memory states dwell until the counter reaches MEM_LAT. The counter is
  // held at zero outside these states and cleared on the exit cycle, so it
  // always enters the next memory state at zero.
  assign wait_st = (state == ST_FETCH) || (state == ST_MEMRD) || (state == ST_MEMWR);

  wait_ctr #(
    .MEM_LAT(MEM_LAT)
  ) u_wait_ctr (
    .clk  (clk),
    .reset(reset),
    .clear(~wait_st | done),
    .en   (wait_st),
    .done (done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
      op_q  <= '0;
    end else begin
      state <= next_state;
      if (state == ST_DECODE) begin
        op_q <= op;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH:   if (done) next_state = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = ST_MEMADR;
          OP_RTYPE:     next_state = ST_RTYPEEX;
          OP_BEQ:       next_state = ST_BEQEX;
          OP_BNE:       next_state = ST_BNEEX;
          OP_ADDI:      next_state = ST_ADDIEX;
          OP_ORI:       next_state = ST_ORIEX;
          OP_J:         next_state = ST_JEX;
          default:      next_state = ST_ILLEGAL;
        endcase
      end
      // The IR may have changed by now; the opcode captured in DECODE decides.
      ST_MEMADR:  next_state = (op_q == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:   if (done) next_state = ST_MEMWB;
      ST_MEMWR:   if (done) next_state = ST_FETCH;
      ST_RTYPEEX: next_state = ST_RTYPEWB;
      ST_ADDIEX:  next_state = ST_IMMWB;
      ST_ORIEX:   next_state = ST_IMMWB;
      default:    next_state = ST_FETCH;
    endcase
  end

  // Reset gates every output, so an instruction interrupted mid-dwell cannot
  // fire a strobe in the reset cycle.
  always_comb begin
    pcwrite   = 1'b0;
    irwrite   = 1'b0;
    memwrite  = 1'b0;
    regwrite  = 1'b0;
    iord      = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = ALUSRCB_RT;
    aluop     = ALUOP_ADD;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    pcsrc     = PCSRC_ALU;
    branch    = 1'b0;
    branchNot = 1'b0;
    illegal   = 1'b0;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          alusrcb = ALUSRCB_FOUR;
          aluop   = ALUOP_ADD;
          irwrite = done;
          pcwrite = done;
        end
        ST_DECODE:  alusrcb = ALUSRCB_SIMM_SH;
        ST_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = ALUSRCB_SIMM;
        end
        ST_MEMRD:   iord = 1'b1;
        ST_MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        ST_MEMWR: begin
          iord     = 1'b1;
          memwrite = done;
        end
        ST_RTYPEEX: begin
          alusrca = 1'b1;
          aluop   = ALUOP_FUNCT;
        end
        ST_RTYPEWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        ST_BEQEX: begin
          alusrca = 1'b1;
          aluop   = ALUOP_SUB;
          pcsrc   = PCSRC_ALUOUT;
          branch  = 1'b1;
        end
        ST_BNEEX: begin
          alusrca   = 1'b1;
          aluop     = ALUOP_SUB;
          pcsrc     = PCSRC_ALUOUT;
          branchNot = 1'b1;
        end
        ST_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = ALUSRCB_SIMM;
        end
        ST_ORIEX: begin
          alusrca = 1'b1;
          alusrcb = ALUSRCB_ZIMM;
          aluop   = ALUOP_OR;
        end
        ST_IMMWB:   regwrite = 1'b1;
        ST_JEX: begin
          pcsrc   = PCSRC_JUMP;
          pcwrite = 1'b1;
        end
        ST_ILLEGAL: illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_maindec.sv
// tb/tb_mc_maindec.sv - scoreboard bench for mc_maindec at MEM_LAT 0, 2 and 3
module tb_mc_maindec;

  // Output vector order:
  // {pcwrite, irwrite, memwrite, regwrite, iord, alusrca, alusrcb[2:0],
  //  aluop[1:0], regdst, memtoreg, pcsrc[1:0], branch, branchNot, illegal}
  localparam logic [17:0] E_ZERO    = 18'b0000_00_000_00_0_0_00_0_0_0;
  localparam logic [17:0] E_FETCH_W = 18'b0000_00_001_00_0_0_00_0_0_0;
  localparam logic [17:0] E_FETCH_F = 18'b1100_00_001_00_0_0_00_0_0_0;
  localparam logic [17:0] E_DECODE  = 18'b0000_00_011_00_0_0_00_0_0_0;
  localparam logic [17:0] E_MEMADR  = 18'b0000_01_010_00_0_0_00_0_0_0;
  localparam logic [17:0] E_MEMRD   = 18'b0000_10_000_00_0_0_00_0_0_0;
  localparam logic [17:0] E_MEMWB   = 18'b0001_00_000_00_0_1_00_0_0_0;
  localparam logic [17:0] E_MEMWR_W = 18'b0000_10_000_00_0_0_00_0_0_0;
  localparam logic [17:0] E_MEMWR_F = 18'b0010_10_000_00_0_0_00_0_0_0;
  localparam logic [17:0] E_RTYPEEX = 18'b0000_01_000_10_0_0_00_0_0_0;
  localparam logic [17:0] E_RTYPEWB = 18'b0001_00_000_00_1_0_00_0_0_0;
  localparam logic [17:0] E_BEQEX   = 18'b0000_01_000_01_0_0_01_1_0_0;
  localparam logic [17:0] E_BNEEX   = 18'b0000_01_000_01_0_0_01_0_1_0;
  localparam logic [17:0] E_ADDIEX  = 18'b0000_01_010_00_0_0_00_0_0_0;
  localparam logic [17:0] E_ORIEX   = 18'b0000_01_100_11_0_0_00_0_0_0;
  localparam logic [17:0] E_IMMWB   = 18'b0001_00_000_00_0_0_00_0_0_0;
  localparam logic [17:0] E_JEX     = 18'b1000_00_000_00_0_0_10_0_0_0;
  localparam logic [17:0] E_ILLEGAL = 18'b0000_00_000_00_0_0_00_0_0_1;

  logic       clk = 1'b0;
  logic [2:0] rstv = 3'b111;
  logic [5:0] op = 6'b000000;
  int         sel = 0;
  wire [17:0] ov [3];

  logic [17:0] exp_q [$];
  string       name_q [$];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mc_maindec #(
      .MEM_LAT((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) u_dut (
      .clk      (clk),
      .reset    (rstv[g]),
      .op       (op),
      .pcwrite  (ov[g][17]),
      .irwrite  (ov[g][16]),
      .memwrite (ov[g][15]),
      .regwrite (ov[g][14]),
      .iord     (ov[g][13]),
      .alusrca  (ov[g][12]),
      .alusrcb  (ov[g][11:9]),
      .aluop    (ov[g][8:7]),
      .regdst   (ov[g][6]),
      .memtoreg (ov[g][5]),
      .pcsrc    (ov[g][4:3]),
      .branch   (ov[g][2]),
      .branchNot(ov[g][1]),
      .illegal  (ov[g][0])
    );
  end

  // Monitor: compares the selected instance's outputs mid-cycle.
  always @(negedge clk) begin
    logic [17:0] e;
    logic [17:0] a;
    string       n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = ov[sel];
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got %b expected %b", n, a, e);
      end
    end
  end

  // Start a cycle: drive inputs for instance s, then queue what it must show.
  task automatic step(input int s, input logic r, input logic [5:0] o,
                      input logic [17:0] e, input string n);
    @(posedge clk);
    #1;
    sel  = s;
    rstv = 3'b111;
    rstv[s] = r;
    op   = o;
    exp_q.push_back(e);
    name_q.push_back($sformatf("lat_inst%0d %s", s, n));
  endtask

  initial begin
    // MEM_LAT=0: reset, then LW in 5 cycles
    step(0, 1'b1, 6'b100011, E_ZERO,    "reset0");
    step(0, 1'b1, 6'b100011, E_ZERO,    "reset1");
    step(0, 1'b0, 6'b100011, E_FETCH_F, "lw_fetch");
    step(0, 1'b0, 6'b100011, E_DECODE,  "lw_decode");
    step(0, 1'b0, 6'b100011, E_MEMADR,  "lw_memadr");
    step(0, 1'b0, 6'b100011, E_MEMRD,   "lw_memrd");
    step(0, 1'b0, 6'b100011, E_MEMWB,   "lw_memwb");
    // BNE
    step(0, 1'b0, 6'b000101, E_FETCH_F, "bne_fetch");
    step(0, 1'b0, 6'b000101, E_DECODE,  "bne_decode");
    step(0, 1'b0, 6'b000101, E_BNEEX,   "bne_ex");
    // BEQ
    step(0, 1'b0, 6'b000100, E_FETCH_F, "beq_fetch");
    step(0, 1'b0, 6'b000100, E_DECODE,  "beq_decode");
    step(0, 1'b0, 6'b000100, E_BEQEX,   "beq_ex");
    // ORI
    step(0, 1'b0, 6'b001101, E_FETCH_F, "ori_fetch");
    step(0, 1'b0, 6'b001101, E_DECODE,  "ori_decode");
    step(0, 1'b0, 6'b001101, E_ORIEX,   "ori_ex");
    step(0, 1'b0, 6'b001101, E_IMMWB,   "ori_wb");
    // RTYPE
    step(0, 1'b0, 6'b000000, E_FETCH_F, "rtype_fetch");
    step(0, 1'b0, 6'b000000, E_DECODE,  "rtype_decode");
    step(0, 1'b0, 6'b000000, E_RTYPEEX, "rtype_ex");
    step(0, 1'b0, 6'b000000, E_RTYPEWB, "rtype_wb");
    // J
    step(0, 1'b0, 6'b000010, E_FETCH_F, "j_fetch");
    step(0, 1'b0, 6'b000010, E_DECODE,  "j_decode");
    step(0, 1'b0, 6'b000010, E_JEX,     "j_ex");
    // illegal opcode, then back to FETCH
    step(0, 1'b0, 6'b111111, E_FETCH_F, "ill_fetch");
    step(0, 1'b0, 6'b111111, E_DECODE,  "ill_decode");
    step(0, 1'b0, 6'b111111, E_ILLEGAL, "ill_state");
    // ADDI
    step(0, 1'b0, 6'b001000, E_FETCH_F, "addi_fetch");
    step(0, 1'b0, 6'b001000, E_DECODE,  "addi_decode");
    step(0, 1'b0, 6'b001000, E_ADDIEX,  "addi_ex");
    step(0, 1'b0, 6'b001000, E_IMMWB,   "addi_wb");
    step(0, 1'b0, 6'b001000, E_FETCH_F, "addi_next");

    // MEM_LAT=2: SW in 8 cycles
    step(1, 1'b1, 6'b101011, E_ZERO,    "reset");
    step(1, 1'b0, 6'b101011, E_FETCH_W, "sw_fetch0");
    step(1, 1'b0, 6'b101011, E_FETCH_W, "sw_fetch1");
    step(1, 1'b0, 6'b101011, E_FETCH_F, "sw_fetch2");
    step(1, 1'b0, 6'b101011, E_DECODE,  "sw_decode");
    step(1, 1'b0, 6'b101011, E_MEMADR,  "sw_memadr");
    step(1, 1'b0, 6'b101011, E_MEMWR_W, "sw_memwr0");
    step(1, 1'b0, 6'b101011, E_MEMWR_W, "sw_memwr1");
    step(1, 1'b0, 6'b101011, E_MEMWR_F, "sw_memwr2");
    step(1, 1'b0, 6'b101011, E_FETCH_W, "sw_next");

    // MEM_LAT=3: reset in second MEMRD cycle of an LW
    step(2, 1'b1, 6'b100011, E_ZERO,    "reset");
    step(2, 1'b0, 6'b100011, E_FETCH_W, "lw_fetch0");
    step(2, 1'b0, 6'b100011, E_FETCH_W, "lw_fetch1");
    step(2, 1'b0, 6'b100011, E_FETCH_W, "lw_fetch2");
    step(2, 1'b0, 6'b100011, E_FETCH_F, "lw_fetch3");
    step(2, 1'b0, 6'b100011, E_DECODE,  "lw_decode");
    step(2, 1'b0, 6'b100011, E_MEMADR,  "lw_memadr");
    step(2, 1'b0, 6'b100011, E_MEMRD,   "lw_memrd0");
    step(2, 1'b1, 6'b100011, E_ZERO,    "lw_memrd1_reset");
    step(2, 1'b0, 6'b111111, E_FETCH_W, "restart_fetch0");
    step(2, 1'b0, 6'b111111, E_FETCH_W, "restart_fetch1");
    step(2, 1'b0, 6'b111111, E_FETCH_W, "restart_fetch2");
    step(2, 1'b0, 6'b111111, E_FETCH_F, "restart_fetch3");
    step(2, 1'b0, 6'b111111, E_DECODE,  "restart_decode");
    step(2, 1'b0, 6'b111111, E_ILLEGAL, "restart_illegal");
    step(2, 1'b0, 6'b111111, E_FETCH_W, "restart_next");

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
